// File: rtl/nonce_sched_if.sv
// Scheduler <-> SHA core handshake: launch pulse plus nonce out, done pulse plus hash word back.
interface nonce_sched_if;
    logic        core_start;
    logic [31:0] core_nonce;
    logic        core_done;
    logic [31:0] core_hash_msw;

    modport master (
        output core_start,
        output core_nonce,
        input  core_done,
        input  core_hash_msw
    );

    modport slave (
        input  core_start,
        input  core_nonce,
        output core_done,
        output core_hash_msw
    );
endinterface

// File: rtl/nonce_sched.sv
// Nonce sweep scheduler: launches the SHA core once per nonce in [nonce_start, nonce_end],
// checks the returned hash MS word against a target and reports found/exhausted/timeout.
module nonce_sched #(
    parameter int unsigned TIMEOUT = 128
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        nonce_start,
    input  logic [31:0]        nonce_end,
    input  logic [31:0]        target_msw,
    nonce_sched_if.master      core,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               exhausted,
    output logic               err,
    output logic [31:0]        found_nonce,
    output logic [31:0]        attempts
);

    localparam int unsigned WDOG_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned NONCE_W  = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        CHECK  = 3'd3,
        TERM   = 3'd4
    } state_t;

    state_t               state, state_d;
    logic [NONCE_W-1:0]   cur, cur_d;
    logic [NONCE_W-1:0]   end_q, end_d;
    logic [NONCE_W-1:0]   tgt_q, tgt_d;
    logic [NONCE_W-1:0]   hash_q, hash_d;
    logic [WDOG_W-1:0]    wdog, wdog_d;
    logic [NONCE_W-1:0]   core_nonce_d;
    logic                 found_d, exhausted_d, err_d;
    logic [NONCE_W-1:0]   found_nonce_d, attempts_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            cur             <= '0;
            end_q           <= '0;
            tgt_q           <= '0;
            hash_q          <= '0;
            wdog            <= '0;
            core.core_start <= 1'b0;
            core.core_nonce <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            found           <= 1'b0;
            exhausted       <= 1'b0;
            err             <= 1'b0;
            found_nonce     <= '1;
            attempts        <= '0;
        end else begin
            state           <= state_d;
            cur             <= cur_d;
            end_q           <= end_d;
            tgt_q           <= tgt_d;
            hash_q          <= hash_d;
            wdog            <= wdog_d;
            core.core_start <= (state_d == LAUNCH);
            core.core_nonce <= core_nonce_d;
            busy            <= (state_d != IDLE);
            done            <= (state_d == TERM);
            found           <= found_d;
            exhausted       <= exhausted_d;
            err             <= err_d;
            found_nonce     <= found_nonce_d;
            attempts        <= attempts_d;
        end
    end

    // Next-state and datapath update; abort overrides everything outside IDLE
    always_comb begin
        state_d       = state;
        cur_d         = cur;
        end_d         = end_q;
        tgt_d         = tgt_q;
        hash_d        = hash_q;
        wdog_d        = wdog;
        core_nonce_d  = core.core_nonce;
        found_d       = found;
        exhausted_d   = exhausted;
        err_d         = err;
        found_nonce_d = found_nonce;
        attempts_d    = attempts;

        if (state != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        end_d         = nonce_end;
                        tgt_d         = target_msw;
                        found_d       = 1'b0;
                        exhausted_d   = 1'b0;
                        err_d         = 1'b0;
                        attempts_d    = '0;
                        found_nonce_d = '1;
                        if (nonce_start <= nonce_end) begin
                            cur_d        = nonce_start;
                            core_nonce_d = nonce_start;
                            state_d      = LAUNCH;
                        end else begin
                            exhausted_d  = 1'b1;
                            state_d      = TERM;
                        end
                    end
                end
                LAUNCH: begin
                    wdog_d  = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (core.core_done) begin
                        hash_d  = core.core_hash_msw;
                        state_d = CHECK;
                    end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = TERM;
                    end else begin
                        wdog_d  = WDOG_W'(wdog + WDOG_W'(1));
                    end
                end
                CHECK: begin
                    if (attempts != '1)
                        attempts_d = NONCE_W'(attempts + NONCE_W'(1));
                    // End-of-range test precedes the increment so a sweep ending at all-ones never wraps
                    if (hash_q <= tgt_q) begin
                        found_d       = 1'b1;
                        found_nonce_d = cur;
                        state_d       = TERM;
                    end else if (cur == end_q) begin
                        exhausted_d   = 1'b1;
                        state_d       = TERM;
                    end else begin
                        cur_d         = NONCE_W'(cur + NONCE_W'(1));
                        core_nonce_d  = NONCE_W'(cur + NONCE_W'(1));
                        state_d       = LAUNCH;
                    end
                end
                TERM: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_sched.sv
// Self-checking bench for nonce_sched: behavioural SHA core, launch-nonce and result scoreboards.
module tb_nonce_sched;

    localparam int unsigned TIMEOUT = 16;

    typedef struct {
        logic        found;
        logic        exhausted;
        logic        err;
        logic [31:0] found_nonce;
        logic [31:0] attempts;
    } res_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic        abort;
    logic [31:0] nonce_start;
    logic [31:0] nonce_end;
    logic [31:0] target_msw;
    logic        busy, done, found, exhausted, err;
    logic [31:0] found_nonce, attempts;

    nonce_sched_if bus ();

    nonce_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .abort       (abort),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .target_msw  (target_msw),
        .core        (bus.master),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .exhausted   (exhausted),
        .err         (err),
        .found_nonce (found_nonce),
        .attempts    (attempts)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_nonce_q[$];
    logic [31:0] hash_src[$];
    res_t        exp_res[$];
    int          n_launch = 0;
    int          n_done   = 0;
    int          cyc      = 0;
    int          launch_cyc = 0;
    int          done_cyc   = 0;
    int          pend_cnt   = 0;
    int          pend_idx   = 0;
    logic [31:0] pend_hash  = 32'h0;
    bit          core_mute  = 1'b0;
    int          abort_at   = -1;
    int          core_lat   = 2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural core plus output monitor, all sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        bus.core_done = 1'b0;
        abort = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.core_done     = 1'b1;
                bus.core_hash_msw = pend_hash;
                if (pend_idx == abort_at)
                    abort = 1'b1;
            end
        end
        if (bus.core_start) begin
            n_launch++;
            launch_cyc = cyc;
            if (exp_nonce_q.size() == 0)
                check_eq("launch_extra", bus.core_nonce, 32'hDEAD_BEEF);
            else
                check_eq("launch_nonce", bus.core_nonce, exp_nonce_q.pop_front());
            if (!core_mute) begin
                pend_hash = (hash_src.size() != 0) ? hash_src.pop_front() : 32'hFFFF_FFFF;
                pend_cnt  = core_lat;
                pend_idx  = n_launch;
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
            if (exp_res.size() == 0) begin
                check_eq("done_unexp", 32'd1, 32'd0);
            end else begin
                res_t r;
                r = exp_res.pop_front();
                check_eq("found",       32'(found),     32'(r.found));
                check_eq("exhausted",   32'(exhausted), 32'(r.exhausted));
                check_eq("err",         32'(err),       32'(r.err));
                check_eq("found_nonce", found_nonce,    r.found_nonce);
                check_eq("attempts",    attempts,       r.attempts);
            end
        end
    end

    task automatic run(input logic [31:0] s, input logic [31:0] e, input logic [31:0] t);
        @(negedge clk);
        start       = 1'b1;
        nonce_start = s;
        nonce_end   = e;
        target_msw  = t;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy)
            check_eq("idle_budget", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic expect_res(input logic f, input logic x, input logic e,
                              input logic [31:0] fn, input logic [31:0] att);
        res_t r;
        r.found = f; r.exhausted = x; r.err = e; r.found_nonce = fn; r.attempts = att;
        exp_res.push_back(r);
    endtask

    task automatic drain_check(input string tag);
        check_eq({tag, "_launch_left"}, 32'(exp_nonce_q.size()), 32'd0);
        check_eq({tag, "_res_left"},    32'(exp_res.size()),     32'd0);
    endtask

    initial begin
        int d0;
        n_rst       = 1'b0;
        start       = 1'b0;
        nonce_start = '0;
        nonce_end   = '0;
        target_msw  = '0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        check_eq("rst_busy",        32'(busy),      32'd0);
        check_eq("rst_found_nonce", found_nonce,    32'hFFFF_FFFF);
        check_eq("rst_attempts",    attempts,       32'd0);
        check_eq("rst_core_start",  32'(bus.core_start), 32'd0);

        // Hit on third nonce; a start pulse while busy must not restart the sweep
        exp_nonce_q = '{32'd10, 32'd11, 32'd12};
        hash_src    = '{32'd5, 32'd7, 32'd0};
        expect_res(1'b0 + 1'b1, 1'b0, 1'b0, 32'd12, 32'd3);
        d0 = n_done;
        run(32'd10, 32'd13, 32'd0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; nonce_start = 32'd99; nonce_end = 32'd200;
        @(negedge clk);
        start = 1'b0;
        wait_idle(200);
        check_eq("t1_done_cnt", 32'(n_done - d0), 32'd1);
        drain_check("t1");

        // Exhausted without hit
        exp_nonce_q = '{32'd20, 32'd21};
        hash_src    = '{32'd3, 32'd1};
        expect_res(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2);
        run(32'd20, 32'd21, 32'd0);
        wait_idle(200);
        drain_check("t2");

        // Top of nonce space: exactly two launches, no wrap to zero
        exp_nonce_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF};
        hash_src    = '{32'd6, 32'd100};
        expect_res(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2);
        d0 = n_launch;
        run(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd5);
        wait_idle(200);
        check_eq("t3_launches", 32'(n_launch - d0), 32'd2);
        drain_check("t3");

        // Hash equal to target counts as a hit
        exp_nonce_q = '{32'd50, 32'd51};
        hash_src    = '{32'd8, 32'd7};
        expect_res(1'b1, 1'b0, 1'b0, 32'd51, 32'd2);
        run(32'd50, 32'd52, 32'd7);
        wait_idle(200);
        drain_check("t4");

        // Empty range: immediate exhausted, no launch
        expect_res(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0);
        d0 = n_launch;
        run(32'd5, 32'd4, 32'd0);
        wait_idle(20);
        check_eq("t5_launches", 32'(n_launch - d0), 32'd0);
        drain_check("t5");

        // Core never answers: err after TIMEOUT cycles in WAIT
        core_mute   = 1'b1;
        exp_nonce_q = '{32'd60};
        expect_res(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0);
        run(32'd60, 32'd61, 32'd0);
        wait_idle(TIMEOUT + 20);
        check_eq("t6_timeout_lat", 32'(done_cyc - launch_cyc), 32'(TIMEOUT + 1));
        drain_check("t6");
        core_mute = 1'b0;

        // Next start clears err
        exp_nonce_q = '{32'd40};
        hash_src    = '{32'd0};
        expect_res(1'b1, 1'b0, 1'b0, 32'd40, 32'd1);
        run(32'd40, 32'd40, 32'd0);
        wait_idle(200);
        drain_check("t7");

        // Abort coincident with core_done on the second nonce
        exp_nonce_q = '{32'd30, 32'd31};
        hash_src    = '{32'd9, 32'd9, 32'd9};
        abort_at    = n_launch + 2;
        d0 = n_done;
        run(32'd30, 32'd33, 32'd0);
        wait_idle(200);
        repeat (4) @(negedge clk);
        check_eq("t8_attempts", attempts,               32'd1);
        check_eq("t8_done_cnt", 32'(n_done - d0),       32'd0);
        check_eq("t8_busy",     32'(busy),              32'd0);
        check_eq("t8_found",    32'(found),             32'd0);
        drain_check("t8");
        abort_at = -1;
        hash_src.delete();

        // Reset pulse mid-WAIT
        core_mute   = 1'b1;
        exp_nonce_q = '{32'd70};
        run(32'd70, 32'd75, 32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_eq("r_busy",        32'(busy),            32'd0);
        check_eq("r_core_start",  32'(bus.core_start),  32'd0);
        check_eq("r_core_nonce",  bus.core_nonce,       32'd0);
        check_eq("r_done",        32'(done),            32'd0);
        check_eq("r_found",       32'(found),           32'd0);
        check_eq("r_exhausted",   32'(exhausted),       32'd0);
        check_eq("r_err",         32'(err),             32'd0);
        check_eq("r_attempts",    attempts,             32'd0);
        check_eq("r_found_nonce", found_nonce,          32'hFFFF_FFFF);
        @(negedge clk);
        n_rst = 1'b1;
        core_mute = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("r_stay_idle", 32'(busy), 32'd0);
        drain_check("t9");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/nonce_sched.md
NONCE_SCHED -- requirements
Module: nonce_sched

Interface
REQ-001 Parameter TIMEOUT, default 128, meaning max cycles from core_start to core_done before error.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  launch sweep, sampled only in IDLE.
REQ-005 abort  input  1  cancel sweep, sampled in any non-IDLE state.
REQ-006 nonce_start  input  32  first nonce of sweep, latched on accepted start.
REQ-007 nonce_end  input  32  last nonce of sweep inclusive, latched on accepted start.
REQ-008 target_msw  input  32  success threshold on hash MS word, latched on accepted start.
REQ-009 core_start  output  1  one-cycle pulse that launches the SHA core.
REQ-010 core_nonce  output  32  nonce for the core, stable from core_start until next LAUNCH.
REQ-011 core_done  input  1  one-cycle pulse from core, hash word valid.
REQ-012 core_hash_msw  input  32  first 32 bits of final hash, valid with core_done.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 done  output  1  one-cycle pulse on sweep termination (found, exhausted, error).
REQ-015 found  output  1  sticky, golden nonce found.
REQ-016 exhausted  output  1  sticky, range finished without hit.
REQ-017 err  output  1  sticky, core timeout.
REQ-018 found_nonce  output  32  winning nonce; FFFFFFFF when none.
REQ-019 attempts  output  32  number of hashes checked this sweep.

Function
REQ-020 FSM states SHALL be IDLE, LAUNCH, WAIT, CHECK, TERM.
REQ-021 IDLE: start=1 and nonce_start<=nonce_end -> latch inputs, cur=nonce_start, clear found/exhausted/err/attempts, found_nonce=FFFFFFFF, go LAUNCH.
REQ-022 IDLE: start=1 and nonce_start>nonce_end -> clear status, set exhausted, attempts=0, go TERM (no core_start).
REQ-023 start while busy SHALL be ignored.
REQ-024 LAUNCH: core_start=1 for exactly this cycle, core_nonce=cur, watchdog=0, go WAIT.
REQ-025 WAIT: core_done=1 -> register core_hash_msw, go CHECK; else watchdog increments.
REQ-026 WAIT: watchdog reaching TIMEOUT-1 without core_done -> set err, go TERM.
REQ-027 CHECK: attempts increments (saturating at FFFFFFFF).
REQ-028 CHECK: captured hash <= target_msw (unsigned) -> found=1, found_nonce=cur, go TERM.
REQ-029 CHECK: no hit and cur==nonce_end -> exhausted=1, go TERM.
REQ-030 CHECK: no hit and cur!=nonce_end -> cur=cur+1, go LAUNCH; comparison before increment so nonce_end=FFFFFFFF never wraps.
REQ-031 TERM: done=1 for one cycle, go IDLE; status outputs hold until next accepted start.
REQ-032 Per-nonce latency SHALL be core latency + 3 cycles (LAUNCH, done capture, CHECK).
REQ-033 abort=1 in LAUNCH/WAIT/CHECK/TERM -> go IDLE next cycle, no done pulse, no core_start, status flags unchanged, attempts frozen.
REQ-034 abort and core_done same cycle in WAIT: abort wins, hash discarded.
REQ-035 core_done outside WAIT SHALL be ignored.
REQ-036 target_msw=0 SHALL reduce to zero-MS-word check of the hash checker.

Reset
REQ-037 n_rst=0 SHALL force IDLE, core_start=0, core_nonce=0, done=0, found=0, exhausted=0, err=0, attempts=0, found_nonce=FFFFFFFF immediately, mid-sweep included.

Verification
REQ-038 Range 10..13, target 0, hashes 5,7,0 -> core_start for 10,11,12; found=1, found_nonce=12, attempts=3, one done pulse.
REQ-039 Range 20..21, target 0, all hashes nonzero -> exhausted=1, attempts=2, found_nonce=FFFFFFFF.
REQ-040 Range FFFFFFFE..FFFFFFFF, no hit -> exactly 2 launches, exhausted=1, no wrap to 0.
REQ-041 core_done withheld -> err=1 and done after TIMEOUT cycles in WAIT; next start clears err.
REQ-042 abort coincident with core_done on 2nd nonce -> IDLE, no done, attempts=1; n_rst pulse mid-WAIT -> all outputs at reset values.
